// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_arbiter                                                  |
// | Description : Two-requester arbiter for the shared DDR4 memory port.       |
// |               Port 0 is the UART program loader, port 1 is the CPU core    |
// |               load/store unit. One transaction is in flight at a time;     |
// |               ties are broken round-robin, and a missing response is       |
// |               aborted with an error pulse after TIMEOUT cycles in WAIT.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk            system clock                                              |
// |   rst            synchronous active-high reset                             |
// |   reqN_i         request from port N (hold with command until done/err)    |
// |   weN_i          1 = write, 0 = read                                       |
// |   addrN_i        byte address                                              |
// |   wdataN_i       write data                                                |
// |   doneN_o        one-cycle completion pulse for port N                     |
// |   errN_o         one-cycle timeout pulse for port N                        |
// |   rdataN_o       read data, valid with doneN_o, held until next doneN_o    |
// |   m_valid_o      downstream command valid                                  |
// |   m_ready_i      downstream command accepted                               |
// |   m_we_o         command write flag                                        |
// |   m_addr_o       command address                                           |
// |   m_wdata_o      command write data                                        |
// |   m_rvalid_i     downstream response (reads and writes)                    |
// |   m_rdata_i      response data                                             |
// |   busy_o         high whenever the arbiter is not idle                     |
// +----------------------------------------------------------------------------+
module mem_arbiter #(
   parameter int ADDR_W  = 27,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 4096
) (
   input  logic              clk,
   input  logic              rst,
   // Port 0: program loader
   input  logic              req0_i,
   input  logic              we0_i,
   input  logic [ADDR_W-1:0] addr0_i,
   input  logic [DATA_W-1:0] wdata0_i,
   output logic              done0_o,
   output logic              err0_o,
   output logic [DATA_W-1:0] rdata0_o,
   // Port 1: core load/store unit
   input  logic              req1_i,
   input  logic              we1_i,
   input  logic [ADDR_W-1:0] addr1_i,
   input  logic [DATA_W-1:0] wdata1_i,
   output logic              done1_o,
   output logic              err1_o,
   output logic [DATA_W-1:0] rdata1_o,
   // Memory-controller bridge
   output logic              m_valid_o,
   input  logic              m_ready_i,
   output logic              m_we_o,
   output logic [ADDR_W-1:0] m_addr_o,
   output logic [DATA_W-1:0] m_wdata_o,
   input  logic              m_rvalid_i,
   input  logic [DATA_W-1:0] m_rdata_i,
   // Status
   output logic              busy_o
);

   // The counter only ever has to hold 0 .. TIMEOUT-1.
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_ISSUE = 2'd1;
   localparam logic [1:0] c_WAIT  = 2'd2;

   logic [1:0]        state_q,      state_d;
   // Port that won the most recent grant; also identifies the owner of the
   // transaction in flight, since it is updated at grant time.
   logic              last_grant_q, last_grant_d;
   logic [CNT_W-1:0]  cnt_q,        cnt_d;
   logic              m_we_q,       m_we_d;
   logic [ADDR_W-1:0] m_addr_q,     m_addr_d;
   logic [DATA_W-1:0] m_wdata_q,    m_wdata_d;
   logic [DATA_W-1:0] rdata0_q,     rdata0_d;
   logic [DATA_W-1:0] rdata1_q,     rdata1_d;
   logic              done0_q,      done0_d;
   logic              done1_q,      done1_d;
   logic              err0_q,       err0_d;
   logic              err1_q,       err1_d;

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      m_we_d       = m_we_q;
      m_addr_d     = m_addr_q;
      m_wdata_d    = m_wdata_q;
      rdata0_d     = rdata0_q;
      rdata1_d     = rdata1_q;
      done0_d      = 1'b0;
      done1_d      = 1'b0;
      err0_d       = 1'b0;
      err1_d       = 1'b0;

      case (state_q)
         c_IDLE: begin
            // Port 0 wins when it is alone, or on a tie when port 1 had the
            // previous grant. Otherwise port 1 wins if it is requesting.
            if (req0_i && (!req1_i || last_grant_q)) begin
               last_grant_d = 1'b0;
               m_we_d       = we0_i;
               m_addr_d     = addr0_i;
               m_wdata_d    = wdata0_i;
               state_d      = c_ISSUE;
            end else if (req1_i) begin
               last_grant_d = 1'b1;
               m_we_d       = we1_i;
               m_addr_d     = addr1_i;
               m_wdata_d    = wdata1_i;
               state_d      = c_ISSUE;
            end
         end

         c_ISSUE: begin
            // Responses arriving before the command is accepted are stray
            // and deliberately ignored here.
            if (m_ready_i) begin
               cnt_d   = '0;
               state_d = c_WAIT;
            end
         end

         c_WAIT: begin
            // A response on the final counted cycle still completes normally.
            if (m_rvalid_i) begin
               if (last_grant_q) begin
                  rdata1_d = m_rdata_i;
                  done1_d  = 1'b1;
               end else begin
                  rdata0_d = m_rdata_i;
                  done0_d  = 1'b1;
               end
               state_d = c_IDLE;
            end else if (cnt_q == c_CNT_LAST) begin
               if (last_grant_q) begin
                  err1_d = 1'b1;
               end else begin
                  err0_d = 1'b1;
               end
               state_d = c_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         default: begin
            state_d = c_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= c_IDLE;
         last_grant_q <= 1'b1;   // first tie after reset goes to port 0
         cnt_q        <= '0;
         m_we_q       <= 1'b0;
         m_addr_q     <= '0;
         m_wdata_q    <= '0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
         done0_q      <= 1'b0;
         done1_q      <= 1'b0;
         err0_q       <= 1'b0;
         err1_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         m_we_q       <= m_we_d;
         m_addr_q     <= m_addr_d;
         m_wdata_q    <= m_wdata_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
         done0_q      <= done0_d;
         done1_q      <= done1_d;
         err0_q       <= err0_d;
         err1_q       <= err1_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs (all driven from registers; no input-to-output paths)
   // -------------------------------------------------------------------------
   assign m_valid_o = (state_q == c_ISSUE);
   assign busy_o    = (state_q != c_IDLE);
   assign m_we_o    = m_we_q;
   assign m_addr_o  = m_addr_q;
   assign m_wdata_o = m_wdata_q;
   assign rdata0_o  = rdata0_q;
   assign rdata1_o  = rdata1_q;
   assign done0_o   = done0_q;
   assign done1_o   = done1_q;
   assign err0_o    = err0_q;
   assign err1_o    = err1_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_arbiter                                               |
// | Description : Directed self-checking bench for mem_arbiter. The memory     |
// |               side is driven cycle by cycle; expected completions are      |
// |               queued when a response is driven and popped on done.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mem_arbiter;

   localparam int AW = 27;
   localparam int DW = 32;
   localparam int TMO = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0, we0, req1, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          done0, err0, done1, err1;
   logic [DW-1:0] rdata0, rdata1;
   logic          m_valid, m_ready, m_we, m_rvalid;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_rdata;
   logic          busy;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      logic          port;
      logic          chk;   // read data is only defined for reads
      logic [DW-1:0] data;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0),
      .done0_o(done0), .err0_o(err0), .rdata0_o(rdata0),
      .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1),
      .done1_o(done1), .err1_o(err1), .rdata1_o(rdata1),
      .m_valid_o(m_valid), .m_ready_i(m_ready), .m_we_o(m_we),
      .m_addr_o(m_addr), .m_wdata_o(m_wdata),
      .m_rvalid_i(m_rvalid), .m_rdata_i(m_rdata),
      .busy_o(busy)
   );

   // Advance one clock; inputs are driven and outputs sampled 1 time unit
   // after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called in the cycle a completion is expected.
   task automatic check_done(input string tag);
      exp_t e;
      vectors++;
      assert (sb.size() != 0)
      else begin
         miscompares++;
         $error("FAIL %s_sb: observed empty scoreboard expected entry", tag);
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({tag, "_done0"}, done0, !e.port);
         chk({tag, "_done1"}, done1, e.port);
         chk({tag, "_err"}, {err1, err0}, 0);
         if (e.chk) chk({tag, "_rdata"}, e.port ? rdata1 : rdata0, e.data);
      end
   endtask

   task automatic push_exp(input logic port, input logic chkd, input logic [DW-1:0] data);
      exp_t e;
      e.port = port;
      e.chk  = chkd;
      e.data = data;
      sb.push_back(e);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      m_ready = 0; m_rvalid = 0; m_rdata = '0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_mvalid"}, m_valid, 0);
      chk({tag, "_done_err"}, {done1, done0, err1, err0}, 0);
      chk({tag, "_mcmd"}, {m_we, m_addr}, 0);
      chk({tag, "_mwdata"}, m_wdata, 0);
      chk({tag, "_rdata0"}, rdata0, 0);
      chk({tag, "_rdata1"}, rdata1, 0);
   endtask

   initial begin
      logic [DW-1:0] r;
      logic          own;

      // ---------------- Reset state
      do_reset();
      check_reset_vals("rst");

      // ---------------- 1: single read on port 1, latency N+1 / N+3
      req1 = 1; we1 = 0; addr1 = 27'h100;
      step();                                    // N+1
      chk("t1_mvalid", m_valid, 1);
      chk("t1_maddr", m_addr, 32'h100);
      chk("t1_mwe", m_we, 0);
      m_ready = 1;
      step();                                    // N+2 (WAIT)
      chk("t1_mvalid_off", m_valid, 0);
      m_ready = 0; req1 = 0;
      m_rvalid = 1; m_rdata = 32'hDEADBEEF;
      push_exp(1'b1, 1'b1, 32'hDEADBEEF);
      step();                                    // N+3
      m_rvalid = 0;
      check_done("t1");
      chk("t1_rdata0_untouched", rdata0, 0);
      step();
      chk("t1_done_once", {done1, done0}, 0);
      chk("t1_idle", busy, 0);

      // ---------------- 2: continuous tie, writes, alternating grants
      do_reset();
      req0 = 1; we0 = 1; addr0 = 27'h10; wdata0 = 32'hA0A0A0A0;
      req1 = 1; we1 = 1; addr1 = 27'h20; wdata1 = 32'hB1B1B1B1;
      for (int i = 0; i < 4; i++) begin
         own = 1'(i % 2);
         step();                                 // ISSUE
         chk("t2_mvalid", m_valid, 1);
         chk("t2_mwe", m_we, 1);
         chk("t2_maddr", m_addr, own ? 32'h20 : 32'h10);
         chk("t2_mwdata", m_wdata, own ? 32'hB1B1B1B1 : 32'hA0A0A0A0);
         m_ready = 1;
         step();                                 // WAIT
         m_ready = 0;
         m_rvalid = 1; m_rdata = $urandom;
         push_exp(own, 1'b0, m_rdata);
         step();                                 // done; next grant sampled now
         m_rvalid = 0;
         if (i == 3) begin
            req0 = 0; req1 = 0;
         end
         check_done("t2");
      end
      step();
      chk("t2_idle", busy, 0);

      // ---------------- 3: backpressure
      do_reset();
      req0 = 1; we0 = 0; addr0 = 27'h55; wdata0 = 32'h5555AAAA;
      step();
      req0 = 0;
      for (int i = 0; i < 5; i++) begin
         chk("t3_mvalid_hold", m_valid, 1);
         chk("t3_maddr_hold", m_addr, 32'h55);
         chk("t3_mwdata_hold", m_wdata, 32'h5555AAAA);
         chk("t3_busy", busy, 1);
         step();
      end
      chk("t3_mvalid_still", m_valid, 1);
      m_ready = 1;
      step();
      m_ready = 0;
      chk("t3_one_accept", m_valid, 0);
      chk("t3_busy_wait", busy, 1);
      m_rvalid = 1; m_rdata = 32'h12345678;
      push_exp(1'b0, 1'b1, 32'h12345678);
      step();
      m_rvalid = 0;
      check_done("t3");

      // ---------------- 4: timeout on port 0
      req0 = 1; we0 = 0; addr0 = 27'h77;
      step();                                    // ISSUE
      m_ready = 1; req0 = 0;
      step();                                    // accept edge just passed
      m_ready = 0;
      for (int k = 1; k < TMO; k++) begin
         step();
         chk("t4_no_err_yet", {err0, done0}, 0);
         chk("t4_busy", busy, 1);
      end
      step();                                    // TMO edges after accept
      chk("t4_err0", err0, 1);
      chk("t4_no_done", {done1, done0, err1}, 0);
      chk("t4_rdata0_kept", rdata0, 32'h12345678);
      chk("t4_idle", busy, 0);
      req0 = 1; we0 = 0; addr0 = 27'h78;
      step();
      chk("t4_err_pulse", err0, 0);
      chk("t4_regrant", m_valid, 1);
      chk("t4_regrant_addr", m_addr, 32'h78);
      m_ready = 1; req0 = 0;
      step();
      m_ready = 0;
      m_rvalid = 1; m_rdata = 32'hCAFEF00D;
      push_exp(1'b0, 1'b1, 32'hCAFEF00D);
      step();
      m_rvalid = 0;
      check_done("t4");

      // ---------------- 5: reset while in WAIT, then stray response
      req1 = 1; we1 = 0; addr1 = 27'h1F0;
      step();
      m_ready = 1; req1 = 0;
      step();
      m_ready = 0;
      step();                                    // still in WAIT
      chk("t5_in_wait", busy, 1);
      rst = 1;
      step();
      rst = 0;
      m_rvalid = 1; m_rdata = 32'h0BADBAD0;
      step();
      m_rvalid = 0;
      check_reset_vals("t5");
      step();
      chk("t5_no_late_done", {done1, done0, err1, err0}, 0);

      // ---------------- 6: stray responses in IDLE and ISSUE
      m_rvalid = 1; m_rdata = 32'h11111111;
      step();
      m_rvalid = 0;
      step();
      chk("t6_idle_stray", {done1, done0, busy}, 0);
      chk("t6_idle_rdata0", rdata0, 0);
      req0 = 1; we0 = 0; addr0 = 27'h9;
      step();                                    // ISSUE, hold off accept
      req0 = 0;
      m_rvalid = 1; m_rdata = 32'h22222222;
      step();
      m_rvalid = 0;
      chk("t6_issue_mvalid", m_valid, 1);
      step();
      chk("t6_issue_stray", {done1, done0}, 0);
      chk("t6_issue_rdata0", rdata0, 0);
      m_ready = 1;
      step();
      m_ready = 0;
      r = 32'h600D600D;
      m_rvalid = 1; m_rdata = r;
      push_exp(1'b0, 1'b1, r);
      step();
      m_rvalid = 0;
      check_done("t6");
      chk("t6_rdata1_untouched", rdata1, 0);

      chk("sb_drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter that shares the single DDR4 memory port between the UART program loader (port 0) and the CPU core load/store unit (port 1).
- Sits between both requesters and the memory-controller bridge in the top-level block design.
- Keeps one transaction outstanding at a time, uses round-robin fairness, and signals an error on a response timeout.

Parameters:
- ADDR_W, 27, byte-address width of all address ports.
- DATA_W, 32, data width of all data ports.
- TIMEOUT, 4096, number of cycles in WAIT before the transaction is aborted with an error.

Ports:
- clk  in  1  system clock; sole clock of the block.
- rst  in  1  synchronous, active-high reset.
- req0 / req1  in  1  request from port 0 (loader) / port 1 (core).
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  ADDR_W  address.
- wdata0 / wdata1  in  DATA_W  write data.
- done0 / done1  out  1  one-cycle completion pulse.
- err0 / err1  out  1  one-cycle timeout pulse; mutually exclusive with done.
- rdata0 / rdata1  out  DATA_W  read data; valid with done, held until that port's next done.
- m_valid  out  1  downstream command valid.
- m_ready  in  1  downstream command accepted.
- m_we  out  1  command write flag.
- m_addr  out  ADDR_W  command address.
- m_wdata  out  DATA_W  command write data.
- m_rvalid  in  1  downstream response; asserted for both reads and writes.
- m_rdata  in  DATA_W  response data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset, sampled on the clk edge:
  - State goes to IDLE and last_grant is set to 1.
  - timeout counter is cleared.
  - done*, err*, m_valid and busy are 0; m_we, m_addr, m_wdata and rdata* are 0.
- Reset mid-transaction aborts immediately: no done or err is issued. A late m_rvalid arriving in IDLE is ignored.
- Requester contract: hold req and the command fields stable until done or err. The arbiter latches the command at grant, so a change or drop of req after grant does not affect the transaction; done still pulses.
- State IDLE:
  - If exactly one req is high, grant that port.
  - If both are high, grant the port opposite last_grant. After reset the first tie therefore goes to port 0.
  - On grant: latch we/addr/wdata into the m_* registers, update last_grant, go to ISSUE. No req keeps the block in IDLE.
- State ISSUE:
  - m_valid = 1 with stable m_* fields.
  - When m_valid && m_ready, go to WAIT and clear the timeout counter.
  - m_rvalid in ISSUE is ignored.
- State WAIT:
  - m_valid = 0 and the counter increments each cycle.
  - On m_rvalid: capture m_rdata into rdata of the granted port (writes capture as well; value unspecified), pulse done of the granted port next cycle, go to IDLE.
  - If the counter reaches TIMEOUT - 1 without m_rvalid: pulse err of the granted port, go to IDLE. rdata is unchanged.
- Latency:
  - req high at edge N → m_valid high from N+1.
  - With m_ready at N+1 and m_rvalid at N+2 → done at N+3.
  - A new grant is possible in the cycle done is high, so the minimum issue interval is 3 cycles.
- done/err are registered and assert for exactly one cycle per transaction. Port data paths never mix: port 1 rdata is untouched by port 0 transactions.

Test Plan:
1. Single read, port 1: req1 with addr1=0x100; memory model gives m_ready immediately and m_rvalid one cycle later with 0xDEADBEEF → m_addr=0x100, m_we=0, done1 pulses once at N+3, rdata1=0xDEADBEEF, done0 stays 0.
2. Tie after reset: req0 and req1 both high continuously, each a write → grants alternate 0,1,0,1; four done pulses in order done0, done1, done0, done1; m_wdata matches the owning port each time.
3. Backpressure: m_ready held low 5 cycles → m_valid stays high with m_addr/m_wdata stable throughout; exactly one accept; busy stays 1 until done.
4. Timeout with TIMEOUT=16: m_rvalid is never returned → err0 pulses 16 cycles after the accept, done0 stays 0, rdata0 is unchanged; a next req0 is granted normally.
5. Reset mid-WAIT: rst asserted one cycle in WAIT, then a stray m_rvalid → no done or err, busy=0, all outputs at reset values, state IDLE.
6. Stray response: m_rvalid pulsed while IDLE and while in ISSUE → ignored; no done, rdata unchanged.
